// File: rtl/scr_arb.sv
// Screen-RAM arbiter: VGA reads own the slot whenever requested, CPU writes are
// posted through a small FIFO, and CPU reads go out only once that FIFO is empty.
module scr_arb #(
    parameter int AW         = 13,
    parameter int DW         = 16,
    parameter int WBUF_DEPTH = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iVGA_REQ,
    input  logic [AW-1:0] iVGA_ADDR,
    output logic [DW-1:0] oVGA_DATA,
    output logic          oVGA_VALID,
    input  logic          iCPU_WR,
    input  logic          iCPU_RD,
    input  logic [AW-1:0] iCPU_ADDR,
    input  logic [DW-1:0] iCPU_WDATA,
    output logic          oCPU_WR_RDY,
    output logic [DW-1:0] oCPU_RD_DATA,
    output logic          oCPU_RD_VALID,
    output logic [AW-1:0] oRAM_ADDR,
    output logic          oRAM_WE,
    output logic [DW-1:0] oRAM_WDATA,
    input  logic [DW-1:0] iRAM_Q
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = $clog2(WBUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(WBUF_DEPTH);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_ISSUE = 2'd2,
        R_DATA  = 2'd3
    } rd_state_t;

    rd_state_t rd_state;
    rd_state_t rd_state_next;

    logic [AW-1:0] fifo_addr [WBUF_DEPTH];
    logic [DW-1:0] fifo_data [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [AW-1:0] rd_addr;
    logic [2:0]    vga_tag;

    logic grant_vga;
    logic grant_wr;
    logic grant_rd;
    logic push;
    logic rd_accept;

    // Handshakes: a write transfers on iCPU_WR & oCPU_WR_RDY; a read request is a
    // level held until the single-cycle oCPU_RD_VALID, and is re-accepted only after it.
    assign grant_vga = iVGA_REQ;
    assign grant_wr  = !iVGA_REQ && (count != '0);
    assign grant_rd  = !iVGA_REQ && (count == '0) && (rd_state == R_WAIT);
    assign push      = iCPU_WR && oCPU_WR_RDY;
    assign rd_accept = (rd_state == R_IDLE) && iCPU_RD && !oCPU_RD_VALID;

    assign oVGA_VALID = vga_tag[2];

    always_comb begin
        count_next = count;
        if (push && !grant_wr) begin
            count_next = count + 1'b1;
        end else if (!push && grant_wr) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            R_IDLE:  if (rd_accept) rd_state_next = R_WAIT;
            R_WAIT:  if (grant_rd) rd_state_next = R_ISSUE;
            R_ISSUE: rd_state_next = R_DATA;
            R_DATA:  rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= iCPU_ADDR;
            fifo_data[wr_ptr] <= iCPU_WDATA;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_state      <= R_IDLE;
            rd_addr       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            oCPU_WR_RDY   <= 1'b0;
            oRAM_ADDR     <= '0;
            oRAM_WE       <= 1'b0;
            oRAM_WDATA    <= '0;
            vga_tag       <= '0;
            oVGA_DATA     <= '0;
            oCPU_RD_DATA  <= '0;
            oCPU_RD_VALID <= 1'b0;
        end else begin
            rd_state    <= rd_state_next;
            count       <= count_next;
            oCPU_WR_RDY <= (count_next < DEPTH_C);
            if (rd_accept) begin
                rd_addr <= iCPU_ADDR;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_wr) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // One RAM slot per cycle; an idle slot keeps address and data.
            oRAM_WE <= 1'b0;
            if (grant_vga) begin
                oRAM_ADDR <= iVGA_ADDR;
            end else if (grant_wr) begin
                oRAM_ADDR  <= fifo_addr[rd_ptr];
                oRAM_WDATA <= fifo_data[rd_ptr];
                oRAM_WE    <= 1'b1;
            end else if (grant_rd) begin
                oRAM_ADDR <= rd_addr;
            end

            // Tag stages: address out, RAM data back, result registered.
            vga_tag <= {vga_tag[1:0], grant_vga};
            if (vga_tag[1]) begin
                oVGA_DATA <= iRAM_Q;
            end

            oCPU_RD_VALID <= (rd_state == R_DATA);
            if (rd_state == R_DATA) begin
                oCPU_RD_DATA <= iRAM_Q;
            end
        end
    end

endmodule

// File: tb/tb_scr_arb.sv
// Directed bench for scr_arb with a synchronous 8Kx16 RAM model and a RAM write log.
module tb_scr_arb;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic          cpu_wr;
    logic          cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          wr_rdy;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_rd_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0]    mem [0:8191];
    logic             mem_ready = 1'b0;
    logic [AW+DW-1:0] wr_log [$];
    logic [AW+DW-1:0] exp_q [$];

    scr_arb #(.AW(AW), .DW(DW), .WBUF_DEPTH(4)) dut (
        .iCLK          (clk),
        .iRST          (rst),
        .iVGA_REQ      (vga_req),
        .iVGA_ADDR     (vga_addr),
        .oVGA_DATA     (vga_data),
        .oVGA_VALID    (vga_valid),
        .iCPU_WR       (cpu_wr),
        .iCPU_RD       (cpu_rd),
        .iCPU_ADDR     (cpu_addr),
        .iCPU_WDATA    (cpu_wdata),
        .oCPU_WR_RDY   (wr_rdy),
        .oCPU_RD_DATA  (cpu_rd_data),
        .oCPU_RD_VALID (cpu_rd_valid),
        .oRAM_ADDR     (ram_addr),
        .oRAM_WE       (ram_we),
        .oRAM_WDATA    (ram_wdata),
        .iRAM_Q        (ram_q)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

    // RAM model: read-before-write, data valid the cycle after the address.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) begin
                mem[i] <= 16'(i) ^ 16'hA5A5;
            end
            mem[16'h0010] <= 16'hBEEF;
            mem_ready <= 1'b1;
        end else begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_log.push_back({ram_addr, ram_wdata});
            end
            ram_q <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", ram_we); end
        vectors++;
        if (vga_valid !== 1'b0) begin miscompares++; $display("FAIL reset_vga_valid: got %b want 0", vga_valid); end
        vectors++;
        if (cpu_rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", cpu_rd_valid); end
        vectors++;
        if (wr_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_wr_rdy: got %b want 0", wr_rdy); end
        vectors++;
        if (ram_addr !== 13'h0) begin miscompares++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        vectors++;
        if ({vga_data, cpu_rd_data, ram_wdata} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h want 0", vga_data, cpu_rd_data, ram_wdata);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (wr_rdy !== 1'b0) begin miscompares++; $display("FAIL release_wr_rdy: got %b want 0", wr_rdy); end
        tick();
        vectors++;
        if (wr_rdy !== 1'b1) begin miscompares++; $display("FAIL rise_wr_rdy: got %b want 1", wr_rdy); end
    endtask

    task automatic test_idle_read();
        int valid_cnt = 0;
        int valid_at = -1;
        int we_cnt = 0;
        logic [DW-1:0] got = '0;
        cpu_rd = 1'b1;
        cpu_addr = 13'h0010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ram_we) we_cnt++;
            if (cpu_rd_valid) begin
                valid_cnt++;
                if (valid_at < 0) valid_at = k;
                got = cpu_rd_data;
                cpu_rd = 1'b0;
            end
        end
        cpu_rd = 1'b0;
        vectors++;
        if (valid_at !== 4) begin miscompares++; $display("FAIL idle_read_latency: got %0d want 4", valid_at); end
        vectors++;
        if (valid_cnt !== 1) begin miscompares++; $display("FAIL idle_read_strobe: got %0d pulses want 1", valid_cnt); end
        vectors++;
        if (got !== 16'hBEEF) begin miscompares++; $display("FAIL idle_read_data: got %h want beef", got); end
        vectors++;
        if (we_cnt !== 0) begin miscompares++; $display("FAIL idle_read_we: got %0d writes want 0", we_cnt); end
    endtask

    task automatic test_vga_latency();
        int cyc;
        logic [DW-1:0] e;
        for (int c = 0; c <= 12; c++) begin
            vga_req   = (c < 8);
            vga_addr  = 13'(c);
            cpu_wr    = (c < 8);
            cpu_addr  = 13'(16'h0100 + c);
            cpu_wdata = 16'(16'h7000 + c);
            tick();
            cyc = c + 1;
            vectors++;
            if (vga_valid !== (cyc >= 3 && cyc <= 10)) begin
                miscompares++;
                $display("FAIL vga_valid_c%0d: got %b want %b", cyc, vga_valid, (cyc >= 3 && cyc <= 10));
            end
            if (cyc >= 3 && cyc <= 10) begin
                e = 16'(cyc - 3) ^ 16'hA5A5;
                vectors++;
                if (vga_data !== e) begin miscompares++; $display("FAIL vga_data_c%0d: got %h want %h", cyc, vga_data, e); end
            end
            if (cyc <= 8) begin
                vectors++;
                if (ram_we !== 1'b0) begin miscompares++; $display("FAIL vga_window_we_c%0d: got %b want 0", cyc, ram_we); end
            end
        end
        vga_req = 1'b0;
        cpu_wr = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_buffer_full();
        int cyc;
        wr_log.delete();
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            vga_req   = 1'b1;
            vga_addr  = 13'(16'h0020 + c);
            cpu_wr    = (c < 5);
            cpu_addr  = 13'(16'h0200 + c);
            cpu_wdata = 16'(16'h5A00 + c);
            tick();
            cyc = c + 1;
            vectors++;
            if (ram_we !== 1'b0) begin miscompares++; $display("FAIL full_we_c%0d: got %b want 0", cyc, ram_we); end
            if (cyc <= 5) begin
                vectors++;
                if (wr_rdy !== (cyc < 4)) begin miscompares++; $display("FAIL full_rdy_c%0d: got %b want %b", cyc, wr_rdy, (cyc < 4)); end
            end
        end
        vga_req = 1'b0;
        cpu_wr = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) exp_q.push_back({13'(16'h0200 + i), 16'(16'h5A00 + i)});
        vectors++;
        if (wr_log.size() !== 4) begin miscompares++; $display("FAIL full_retired: got %0d writes want 4", wr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wr_log.size()) begin
                vectors++;
                if (wr_log[i] !== exp_q[i]) begin miscompares++; $display("FAIL full_order_%0d: got %h want %h", i, wr_log[i], exp_q[i]); end
            end
        end
        vectors++;
        if (wr_rdy !== 1'b1) begin miscompares++; $display("FAIL full_rdy_after: got %b want 1", wr_rdy); end
    endtask

    task automatic test_read_after_write();
        int we_at = -1;
        int valid_at = -1;
        logic [DW-1:0] got = '0;
        cpu_wr = 1'b1;
        cpu_rd = 1'b1;
        cpu_addr = 13'h1FFF;
        cpu_wdata = 16'h1234;
        for (int k = 1; k <= 20; k++) begin
            tick();
            cpu_wr = 1'b0;
            if (ram_we && ram_addr == 13'h1FFF && we_at < 0) we_at = k;
            if (cpu_rd_valid && valid_at < 0) begin
                valid_at = k;
                got = cpu_rd_data;
                cpu_rd = 1'b0;
            end
        end
        cpu_rd = 1'b0;
        vectors++;
        if (got !== 16'h1234) begin miscompares++; $display("FAIL raw_data: got %h want 1234", got); end
        vectors++;
        if (we_at !== 2) begin miscompares++; $display("FAIL raw_we_cycle: got %0d want 2", we_at); end
        vectors++;
        if (valid_at !== 5) begin miscompares++; $display("FAIL raw_valid_cycle: got %0d want 5", valid_at); end
    endtask

    task automatic test_push_pop();
        logic vga_v [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic wr_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int cyc;
        wr_log.delete();
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            vga_req   = vga_v[c];
            vga_addr  = 13'h0040;
            cpu_wr    = wr_v[c];
            cpu_addr  = 13'(16'h0400 + c);
            cpu_wdata = 16'(16'hA0A0 + c);
            if (wr_v[c]) exp_q.push_back({13'(16'h0400 + c), 16'(16'hA0A0 + c)});
            tick();
            cyc = c + 1;
            if (cyc == 3) begin
                vectors++;
                if (ram_we !== 1'b1 || ram_addr !== 13'h0400) begin
                    miscompares++;
                    $display("FAIL pushpop_pop: got we=%b addr=%h want we=1 addr=0400", ram_we, ram_addr);
                end
            end
            if (cyc >= 3) begin
                vectors++;
                if (wr_rdy !== (cyc < 5)) begin miscompares++; $display("FAIL pushpop_rdy_c%0d: got %b want %b", cyc, wr_rdy, (cyc < 5)); end
            end
        end
        vga_req = 1'b0;
        cpu_wr = 1'b0;
        repeat (10) tick();
        vectors++;
        if (wr_log.size() !== 5) begin miscompares++; $display("FAIL pushpop_retired: got %0d writes want 5", wr_log.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < wr_log.size()) begin
                vectors++;
                if (wr_log[i] !== exp_q[i]) begin miscompares++; $display("FAIL pushpop_order_%0d: got %h want %h", i, wr_log[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int we_cnt = 0;
        int vv_cnt = 0;
        int cv_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            vga_req   = 1'b1;
            vga_addr  = 13'(16'h0050 + c);
            cpu_wr    = 1'b1;
            cpu_addr  = 13'(16'h0300 + c);
            cpu_wdata = 16'(16'hC000 + c);
            tick();
        end
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        cpu_addr = 13'h0010;
        tick();
        rst = 1'b1;
        vga_req = 1'b0;
        cpu_rd = 1'b0;
        tick();
        rst = 1'b0;
        wr_log.delete();
        vectors++;
        if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rstmid_we: got %b want 0", ram_we); end
        vectors++;
        if (wr_rdy !== 1'b0) begin miscompares++; $display("FAIL rstmid_rdy_low: got %b want 0", wr_rdy); end
        if (vga_valid) vv_cnt++;
        if (cpu_rd_valid) cv_cnt++;
        for (int k = 6; k <= 17; k++) begin
            tick();
            if (ram_we) we_cnt++;
            if (vga_valid) vv_cnt++;
            if (cpu_rd_valid) cv_cnt++;
            if (k == 6) begin
                vectors++;
                if (wr_rdy !== 1'b1) begin miscompares++; $display("FAIL rstmid_rdy_high: got %b want 1", wr_rdy); end
            end
        end
        vectors++;
        if (we_cnt !== 0 || wr_log.size() !== 0) begin
            miscompares++;
            $display("FAIL rstmid_no_write: got %0d writes want 0", we_cnt);
        end
        vectors++;
        if (vv_cnt !== 0) begin miscompares++; $display("FAIL rstmid_vga_valid: got %0d pulses want 0", vv_cnt); end
        vectors++;
        if (cv_cnt !== 0) begin miscompares++; $display("FAIL rstmid_rd_valid: got %0d pulses want 0", cv_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        vga_req = 1'b0;
        vga_addr = '0;
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        test_reset();
        test_idle_read();
        test_vga_latency();
        test_buffer_full();
        test_read_after_write();
        test_push_pop();
        test_reset_mid();
        test_idle_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
